// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared widths, reset PC, fetch-entry record and fetch FSM states
//            for the Citrus CPU front end.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int ADDR_W  = 16;
   localparam int INSTR_W = 32;

   localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

   // One fetched instruction together with the word address it came from
   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Fetch sequencer states, explicitly encoded
   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } fetch_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : DEPTH-entry synchronous FIFO of fetch entries with push, pop and
//            flush. Head is read straight from storage registers.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  fetch_entry_t       push_entry,
   output fetch_entry_t       head_entry,
   output logic [CNT_W-1:0]   count,
   output logic               empty
);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic full;
   logic push_ok;
   logic pop_ok;

   assign full       = (count_q == CNT_W'(DEPTH));
   assign empty      = (count_q == '0);
   assign count      = count_q;
   assign head_entry = mem_q[rd_q];

   // A push into a full queue is only legal when the head leaves the same cycle
   assign push_ok = push & (~full | pop);
   assign pop_ok  = pop & ~empty;

   // Next pointers, occupancy and storage; flush drops everything not yet read
   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push_ok) begin
         mem_d[wr_q] = push_entry;
         wr_d        = wr_q + PTR_W'(1);
      end
      if (flush) begin
         rd_d    = wr_d;
         count_d = '0;
      end else begin
         if (pop_ok) begin
            rd_d = rd_q + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Queue state registers, all cleared on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Citrus instruction-fetch stage. Drives rom64k word address from
//            the PC, captures the returned word, queues {pc, instr} for decode
//            and handles redirects by flushing and reloading the PC.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int                DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_en,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [INSTR_W-1:0] rom_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;

   logic              run_en;
   logic              push;
   logic              pop;
   logic              q_empty;
   logic [CNT_W-1:0]  q_count;
   fetch_entry_t      new_entry;
   fetch_entry_t      head;

   // The ROM sees the PC register directly; nothing sits in between
   assign rom_addr = pc_q;

   assign out_valid = ~q_empty;
   assign out_instr = head.instr;
   assign out_pc    = head.pc;

   assign pop       = out_valid & out_ready;
   assign push      = run_en & fetch_en & ~redirect_valid
                      & ((q_count < CNT_W'(DEPTH)) | pop);
   assign new_entry = '{pc: pc_q, instr: rom_data};

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: boot lasts one cycle, then fetch_en selects run or pause
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_BOOT:  state_d = fetch_en ? S_RUN : S_PAUSE;
         S_RUN:   if (!fetch_en) state_d = S_PAUSE;
         S_PAUSE: if (fetch_en)  state_d = S_RUN;
         default: state_d = S_BOOT;
      endcase
   end

   // FSM output: fetching is only permitted from the run state
   always_comb begin
      run_en = 1'b0;
      if (state_q == S_RUN) begin
         run_en = 1'b1;
      end
   end

   // PC next value: redirect wins, otherwise advance (wrapping) on each push
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (push) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   // PC register
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .flush      (redirect_valid),
      .push_entry (new_entry),
      .head_entry (head),
      .count      (q_count),
      .empty      (q_empty)
   );

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed bench for fetch_unit with a behavioural rom64k and a
//            scoreboard of expected head PCs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic [15:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [15:0] out_pc;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] sb_q [$];

   always #5 clk = ~clk;

   // rom64k stand-in: every address holds a distinct, nonzero word
   function automatic logic [31:0] rom_word(input logic [15:0] a);
      return {a ^ 16'h5A3C, a + 16'h1357};
   endfunction

   assign rom_data = rom_word(rom_addr);

   fetch_unit #(
      .RESET_PC (16'h0000),
      .DEPTH    (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Head must be valid and match the oldest expected PC; it is accepted at the next edge
   task automatic pop_cycle(input string tag);
      logic [15:0] e;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL %s: observed empty scoreboard expected pending entry", tag);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
         chk({tag, "_pc"},    {16'b0, out_pc},    {16'b0, e});
         chk({tag, "_instr"}, out_instr,          rom_word(e));
      end
      tick();
   endtask

   initial begin
      rst            = 1'b1;
      fetch_en       = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      repeat (3) tick();

      // Reset state
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_instr", out_instr,          32'd0);
      chk("rst_pc",    {16'b0, out_pc},    32'd0);
      chk("rst_addr",  {16'b0, rom_addr},  32'd0);

      // Streaming from reset: valid appears two edges after rst drops
      rst       = 1'b0;
      fetch_en  = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("boot_valid", {31'b0, out_valid}, 32'd0);
      tick();
      chk("first_valid", {31'b0, out_valid}, 32'd1);
      chk("first_addr",  {16'b0, rom_addr},  32'd1);
      for (int i = 0; i < 6; i++) sb_q.push_back(16'(i));
      for (int i = 0; i < 6; i++) pop_cycle("stream");

      // Backpressure: queue fills to two, PC stalls at 2
      out_ready = 1'b0;
      rst       = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      repeat (6) tick();
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_pc",    {16'b0, out_pc},    32'd0);
      chk("stall_addr",  {16'b0, rom_addr},  32'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) sb_q.push_back(16'(i));
      for (int i = 0; i < 4; i++) pop_cycle("drain");

      // Redirect with full queue: head (4) consumed, the other entry dropped
      redirect_valid = 1'b1;
      redirect_pc    = 16'h1234;
      pop_cycle("redir_pop");
      redirect_valid = 1'b0;
      chk("redir_bubble", {31'b0, out_valid}, 32'd0);
      chk("redir_addr",   {16'b0, rom_addr},  32'h1234);
      tick();
      sb_q.push_back(16'h1234);
      sb_q.push_back(16'h1235);
      pop_cycle("redir_a");
      pop_cycle("redir_b");

      // Redirect near the top of the address space: PC wraps to zero
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFE;
      sb_q.push_back(16'h1236);
      pop_cycle("wrap_pop");
      redirect_valid = 1'b0;
      chk("wrap_bubble", {31'b0, out_valid}, 32'd0);
      chk("wrap_addr",   {16'b0, rom_addr},  32'hFFFE);
      tick();
      sb_q.push_back(16'hFFFE);
      sb_q.push_back(16'hFFFF);
      sb_q.push_back(16'h0000);
      sb_q.push_back(16'h0001);
      for (int i = 0; i < 4; i++) pop_cycle("wrap");

      // Pause at pc=5: queued entry drains, PC holds, fetch resumes at 5
      sb_q.push_back(16'h0002);
      sb_q.push_back(16'h0003);
      pop_cycle("pre_pause");
      pop_cycle("pre_pause");
      chk("pause_addr0", {16'b0, rom_addr}, 32'd5);
      fetch_en = 1'b0;
      sb_q.push_back(16'h0004);
      pop_cycle("pause_drain");
      chk("pause_valid", {31'b0, out_valid}, 32'd0);
      chk("pause_addr1", {16'b0, rom_addr},  32'd5);
      repeat (2) tick();
      chk("pause_valid2", {31'b0, out_valid}, 32'd0);
      chk("pause_addr2",  {16'b0, rom_addr},  32'd5);
      fetch_en = 1'b1;
      tick();
      chk("resume_bubble", {31'b0, out_valid}, 32'd0);
      tick();
      sb_q.push_back(16'h0005);
      sb_q.push_back(16'h0006);
      pop_cycle("resume");
      pop_cycle("resume");

      // Reset mid-stream with full queue and a redirect pending
      out_ready = 1'b0;
      tick();
      chk("full_valid", {31'b0, out_valid}, 32'd1);
      chk("full_pc",    {16'b0, out_pc},    32'd7);
      rst            = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'hABCD;
      out_ready      = 1'b1;
      tick();
      chk("mrst_valid", {31'b0, out_valid}, 32'd0);
      chk("mrst_addr",  {16'b0, rom_addr},  32'd0);
      chk("mrst_pc",    {16'b0, out_pc},    32'd0);
      chk("mrst_instr", out_instr,          32'd0);
      rst            = 1'b0;
      redirect_valid = 1'b0;
      tick();
      chk("mrst_boot", {31'b0, out_valid}, 32'd0);
      tick();
      sb_q.push_back(16'h0000);
      sb_q.push_back(16'h0001);
      pop_cycle("after_rst");
      pop_cycle("after_rst");

      chk("sb_left", sb_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fetch_unit
`default_nettype wire
